// File: rtl/smc777_vram_arb.sv
// smc777_vram_arb
// Single-port VRAM arbiter for the display fetch, Z80 CPU and ioctl loader.
// Fixed priority every cycle: display > CPU > loader, one access per cycle.
// Accesses are issued one cycle after the grant on registered ram_* outputs.
// Read data comes back from the synchronous RAM one cycle after that, and is
// registered once more before it is presented.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   disp_req/disp_addr          display fetch pulse and address
//   disp_valid/disp_data        fetch result, 3 cycles after disp_req
//   cpu_req/cpu_we/cpu_addr/cpu_din   CPU access, level until cpu_ack
//   cpu_ack/cpu_dout/cpu_wait_n       CPU completion, read data, Z80 WAIT
//   dl_req/dl_addr/dl_din/dl_ack      loader write request and issue pulse
//   ram_addr/ram_we/ram_din/ram_dout  VRAM port
//   cpu_wait_cnt                only with SMC777_VRAM_ARB_STATS_EN defined:
//                               saturating count of cycles with WAIT low
module smc777_vram_arb #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_valid,
  output logic [7:0]    disp_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_ack,
  output logic [7:0]    cpu_dout,
  output logic          cpu_wait_n,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_din,
  output logic          dl_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_din,
  input  logic [7:0]    ram_dout
`ifdef SMC777_VRAM_ARB_STATS_EN
  ,
  output logic [15:0]   cpu_wait_cnt
`endif
);

  logic cpu_busy;
  logic s1_disp, s1_cpu, s1_rd;   // access on the RAM port this cycle
  logic s2_disp, s2_cpu, s2_rd;   // ram_dout belongs to this access

  logic grant_disp, grant_cpu, grant_dl;

  // A CPU request already granted (busy) no longer blocks the loader.
  always_comb begin
    grant_disp = disp_req;
    grant_cpu  = cpu_req & ~cpu_busy & ~disp_req;
    grant_dl   = dl_req & ~disp_req & ~(cpu_req & ~cpu_busy);
  end

  assign cpu_wait_n = ~(cpu_req & ~cpu_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_din    <= '0;
      dl_ack     <= 1'b0;
      cpu_busy   <= 1'b0;
      s1_disp    <= 1'b0;
      s1_cpu     <= 1'b0;
      s1_rd      <= 1'b0;
      s2_disp    <= 1'b0;
      s2_cpu     <= 1'b0;
      s2_rd      <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      cpu_ack    <= 1'b0;
      cpu_dout   <= '0;
    end else begin
      ram_we  <= 1'b0;
      dl_ack  <= 1'b0;
      s1_disp <= grant_disp;
      s1_cpu  <= grant_cpu;
      s1_rd   <= grant_cpu & ~cpu_we;

      if (grant_disp) begin
        ram_addr <= disp_addr;
      end else if (grant_cpu) begin
        ram_addr <= cpu_addr;
        ram_we   <= cpu_we;
        ram_din  <= cpu_din;
      end else if (grant_dl) begin
        ram_addr <= dl_addr;
        ram_we   <= 1'b1;
        ram_din  <= dl_din;
        dl_ack   <= 1'b1;
      end

      s2_disp <= s1_disp;
      s2_cpu  <= s1_cpu;
      s2_rd   <= s1_rd;

      disp_valid <= s2_disp;
      if (s2_disp) disp_data <= ram_dout;
      cpu_ack <= s2_cpu;
      if (s2_cpu && s2_rd) cpu_dout <= ram_dout;

      // Busy spans grant to ack so the still-high cpu_req is not re-granted.
      if (grant_cpu) cpu_busy <= 1'b1;
      else if (cpu_ack) cpu_busy <= 1'b0;
    end
  end

`ifdef SMC777_VRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) cpu_wait_cnt <= '0;
    else if (!cpu_wait_n && cpu_wait_cnt != 16'hFFFF) cpu_wait_cnt <= cpu_wait_cnt + 16'd1;
  end
`endif

endmodule
